// File: rtl/gb_mem_req_bridge.sv
// Game Boy core memory-request bridge: holds one core request, signals the Nios through req_toggle,
// and completes it from an Avalon-MM response. Optional auto-completion timeout: GB_MEMREQ_TIMEOUT_EN.
module gb_mem_req_bridge #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
`ifdef GB_MEMREQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gb_req,
  input  logic              gb_we,
  input  logic [ADDR_W-1:0] gb_addr,
  input  logic [DATA_W-1:0] gb_wdata,
  output logic [DATA_W-1:0] gb_rdata,
  output logic              gb_ack,
  output logic              gb_busy,
  output logic              req_toggle,
  input  logic [1:0]        avs_address,
  input  logic              avs_chipselect,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata
);

  typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              we_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              toggle_reg;
  logic              ovf_reg;
  logic [15:0]       count_reg;
  logic [31:0]       avs_readdata_reg;
  logic [31:0]       readdata_next;
  logic [31:0]       req_word;

  logic pending;
  logic accept;
  logic complete;
  logic wr_resp;
  logic wr_status;
  logic tmo_hit;
  logic tmo_bit;

  assign pending   = (state_reg == PEND);
  assign accept    = (state_reg == IDLE) && gb_req;
  assign wr_resp   = avs_chipselect && avs_write && (avs_address == 2'd1);
  assign wr_status = avs_chipselect && avs_write && (avs_address == 2'd2);

`ifdef GB_MEMREQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_reg;
  logic        tmo_reg;

  // A RESP write landing on the last timeout cycle completes normally instead.
  assign tmo_hit = pending && (tmo_cnt_reg == TMO_LAST) && !wr_resp;
  assign tmo_bit = tmo_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_reg <= 16'd0;
      tmo_reg     <= 1'b0;
    end else begin
      if (accept)
        tmo_cnt_reg <= 16'd0;
      else if (pending)
        tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
      tmo_reg <= (tmo_reg && !(wr_status && avs_writedata[2])) || tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo_bit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    complete   = 1'b0;
    case (state_reg)
      IDLE: if (gb_req) state_next = PEND;
      PEND: begin
        if (wr_resp || tmo_hit) begin
          state_next = ACK;
          complete   = 1'b1;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      we_reg     <= 1'b0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      toggle_reg <= 1'b0;
      ovf_reg    <= 1'b0;
      count_reg  <= 16'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg   <= gb_addr;
        we_reg     <= gb_we;
        wdata_reg  <= gb_wdata;
        toggle_reg <= ~toggle_reg;
      end
      // Writes leave gb_rdata holding whatever the last read returned.
      if (pending && wr_resp && !we_reg)
        rdata_reg <= avs_writedata[DATA_W-1:0];
      else if (tmo_hit && !we_reg)
        rdata_reg <= '1;
      if (complete)
        count_reg <= count_reg + 16'd1;
      ovf_reg <= (ovf_reg && !(wr_status && avs_writedata[1])) ||
                 (gb_req && (state_reg != IDLE));
    end
  end

  always_comb begin
    req_word                 = 32'd0;
    req_word[ADDR_W-1:0]     = addr_reg;
    req_word[16 +: DATA_W]   = wdata_reg;
    req_word[24]             = we_reg;
    req_word[31]             = pending;
    readdata_next            = 32'd0;
    case (avs_address)
      2'd0:    readdata_next = req_word;
      2'd2:    readdata_next = {29'd0, tmo_bit, ovf_reg, pending};
      2'd3:    readdata_next = {16'd0, count_reg};
      default: readdata_next = 32'd0;
    endcase
  end

  // Read data tracks the address every cycle; reads carry no side effects.
  always_ff @(posedge clk) begin
    if (reset)
      avs_readdata_reg <= 32'd0;
    else
      avs_readdata_reg <= readdata_next;
  end

  logic unused_inputs;
  assign unused_inputs = ^{avs_read, avs_writedata};

  assign gb_rdata     = rdata_reg;
  assign gb_ack       = (state_reg == ACK);
  assign gb_busy      = (state_reg != IDLE);
  assign req_toggle   = toggle_reg;
  assign avs_readdata = avs_readdata_reg;

endmodule
